// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the SEQ execute stage: icodes, ALU and
// condition function codes, and condition-code bit positions.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] I_IADDQ  = 4'hC;

    // ALU function; encodings match OPq ifun 0..3
    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } aluFn_e;

    // Condition function codes for cmovXX / jXX
    localparam logic [3:0] C_ALW = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // Condition-code register layout {ZF,SF,OF}
    typedef logic [2:0] ccFlags_t;
    localparam int unsigned ZF = 2;
    localparam int unsigned SF = 1;
    localparam int unsigned OF = 0;

    // Evaluate a condition code against the flags; invalid codes yield 0
    function automatic logic condEval(input ccFlags_t flags, input logic [3:0] fn);
        logic lt;
        logic res;
        lt = flags[SF] ^ flags[OF];
        case (fn)
            C_ALW:   res = 1'b1;
            C_LE:    res = lt | flags[ZF];
            C_L:     res = lt;
            C_E:     res = flags[ZF];
            C_NE:    res = ~flags[ZF];
            C_GE:    res = ~lt;
            C_G:     res = ~lt & ~flags[ZF];
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational Y86-64 ALU: result = aluB <fn> aluA, plus ZF/SF/OF.
module alu
    import y86_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] aluA,
    input  logic [WIDTH-1:0] aluB,
    input  aluFn_e           fn,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    // Operation select and flag generation; carry is discarded
    always_comb begin
        result = '0;
        of     = 1'b0;
        unique case (fn)
            ALU_ADD: begin
                result = aluB + aluA;
                of     = (aluA[WIDTH-1] == aluB[WIDTH-1]) &&
                         (result[WIDTH-1] != aluB[WIDTH-1]);
            end
            ALU_SUB: begin
                result = aluB - aluA;
                of     = (aluA[WIDTH-1] != aluB[WIDTH-1]) &&
                         (result[WIDTH-1] != aluB[WIDTH-1]);
            end
            ALU_AND: result = aluB & aluA;
            ALU_XOR: result = aluB ^ aluA;
        endcase
        zf = (result == '0);
        sf = result[WIDTH-1];
    end

endmodule

// File: rtl/execute.sv
// SEQ execute stage: ALU operand selection, condition evaluation, and the
// execute-side state (CC register, sticky halt, retired counter).
// Optional feature macro: IADDQ_EN enables icode C (iaddq).
module execute
    import y86_pkg::*;
#(
    parameter int unsigned WIDTH    = 64,
    parameter logic [2:0]  CC_RESET = 3'b100,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    output logic [WIDTH-1:0] valE,
    output logic             Cnd,
    output logic [2:0]       cc,
    output logic             halted,
    output logic             ins_err,
    output logic [CNT_W-1:0] retired
);

    logic [WIDTH-1:0] aluA;
    logic [WIDTH-1:0] aluB;
    logic [WIDTH-1:0] aluResult;
    aluFn_e           aluFn;
    logic             aluZf;
    logic             aluSf;
    logic             aluOf;
    logic             useAlu;
    logic             setCc;
    logic             isCond;
    logic             insErr;
    ccFlags_t         ccQ;
    logic             haltedQ;
    logic [CNT_W-1:0] retiredQ;

    alu #(
        .WIDTH (WIDTH)
    ) uAlu (
        .aluA   (aluA),
        .aluB   (aluB),
        .fn     (aluFn),
        .result (aluResult),
        .zf     (aluZf),
        .sf     (aluSf),
        .of     (aluOf)
    );

    // Decode icode/ifun into ALU operands, CC-update and error strobes
    always_comb begin
        aluA   = '0;
        aluB   = '0;
        aluFn  = ALU_ADD;
        useAlu = 1'b0;
        setCc  = 1'b0;
        isCond = 1'b0;
        insErr = 1'b0;
        case (icode)
            I_HALT, I_NOP: ;
            I_JXX: isCond = 1'b1;
            I_RRMOVQ: begin
                aluA   = valA;
                useAlu = 1'b1;
                isCond = 1'b1;
            end
            I_IRMOVQ: begin
                aluA   = valC;
                useAlu = 1'b1;
            end
            I_RMMOVQ, I_MRMOVQ: begin
                aluA   = valC;
                aluB   = valB;
                useAlu = 1'b1;
            end
            I_OPQ: begin
                if (ifun > 4'd3) begin
                    insErr = 1'b1;
                end else begin
                    aluA   = valA;
                    aluB   = valB;
                    aluFn  = aluFn_e'(ifun[1:0]);
                    useAlu = 1'b1;
                    setCc  = 1'b1;
                end
            end
            I_CALL, I_PUSHQ: begin
                aluA   = WIDTH'(8);
                aluB   = valB;
                aluFn  = ALU_SUB;
                useAlu = 1'b1;
            end
            I_RET, I_POPQ: begin
                aluA   = WIDTH'(8);
                aluB   = valB;
                useAlu = 1'b1;
            end
`ifdef IADDQ_EN
            I_IADDQ: begin
                aluA   = valC;
                aluB   = valB;
                useAlu = 1'b1;
                setCc  = 1'b1;
            end
`endif
            default: insErr = 1'b1;
        endcase
        if (isCond && (ifun > C_G)) begin
            insErr = 1'b1;
        end
    end

    // Combinational outputs; Cnd looks only at the registered flags
    always_comb begin
        valE    = useAlu ? aluResult : '0;
        Cnd     = isCond && condEval(ccQ, ifun);
        ins_err = insErr;
    end

    // Architectural state; reset beats a same-cycle halt, halt freezes CC and count
    always_ff @(posedge clk) begin
        if (reset) begin
            ccQ      <= CC_RESET;
            haltedQ  <= 1'b0;
            retiredQ <= '0;
        end else if (!haltedQ) begin
            if (setCc) begin
                ccQ <= {aluZf, aluSf, aluOf};
            end
            if (!insErr) begin
                retiredQ <= retiredQ + 1'b1;
            end
            if (icode == I_HALT) begin
                haltedQ <= 1'b1;
            end
        end
    end

    assign cc      = ccQ;
    assign halted  = haltedQ;
    assign retired = retiredQ;

endmodule

// File: tb/tb_execute.sv
// Table-driven bench for execute with an expected-result queue.
module tb_execute;

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [63:0] e;
        logic        cnd;
        logic        err;
        logic [2:0]  ccAfter;
        int unsigned retAfter;
        logic        haltAfter;
    } vec_t;

`ifdef IADDQ_EN
    localparam bit IaddEn = 1'b1;
`else
    localparam bit IaddEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [63:0] valE;
    logic        Cnd;
    logic [2:0]  cc;
    logic        halted;
    logic        insErr;
    logic [31:0] retired;
    logic [63:0] valE2;
    logic        Cnd2;
    logic [2:0]  cc2;
    logic        halted2;
    logic        insErr2;
    logic [2:0]  retired2;

    int nCmp = 0;
    int nFail = 0;
    vec_t vecs[27];
    vec_t sb[$];

    execute dut (
        .clk     (clk),
        .reset   (reset),
        .icode   (icode),
        .ifun    (ifun),
        .valA    (valA),
        .valB    (valB),
        .valC    (valC),
        .valE    (valE),
        .Cnd     (Cnd),
        .cc      (cc),
        .halted  (halted),
        .ins_err (insErr),
        .retired (retired)
    );

    // Narrow counter instance for the wrap-around check
    execute #(
        .CNT_W (3)
    ) dutNarrow (
        .clk     (clk),
        .reset   (reset),
        .icode   (icode),
        .ifun    (ifun),
        .valA    (valA),
        .valB    (valB),
        .valC    (valC),
        .valE    (valE2),
        .Cnd     (Cnd2),
        .cc      (cc2),
        .halted  (halted2),
        .ins_err (insErr2),
        .retired (retired2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] ic, input logic [3:0] fn,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] c, input logic [63:0] e,
                                input logic cnd, input logic err, input logic [2:0] ccA,
                                input int unsigned ret, input logic h);
        vec_t v;
        v.icode = ic; v.ifun = fn; v.a = a; v.b = b; v.c = c; v.e = e;
        v.cnd = cnd; v.err = err; v.ccAfter = ccA; v.retAfter = ret; v.haltAfter = h;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        reset = rst; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    endtask

    initial begin
        vec_t cur;
        int unsigned r21;
        logic [2:0] cc21;
        r21  = IaddEn ? 19 : 18;
        cc21 = IaddEn ? 3'b000 : 3'b010;

        // icode ifun valA valB valC | valE Cnd err | cc ret halted (after edge)
        vecs[0]  = mk(4'h7, 4'h3, 0, 0, 0, 0, 1, 0, 3'b100, 1, 0);
        vecs[1]  = mk(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0,
                      64'h8000_0000_0000_0000, 0, 0, 3'b011, 2, 0);
        vecs[2]  = mk(4'h7, 4'h2, 0, 0, 0, 0, 0, 0, 3'b011, 3, 0);
        vecs[3]  = mk(4'h6, 4'h1, 5, 5, 0, 0, 0, 0, 3'b100, 4, 0);
        vecs[4]  = mk(4'h2, 4'h4, 64'h55, 64'h99, 0, 64'h55, 0, 0, 3'b100, 5, 0);
        vecs[5]  = mk(4'h2, 4'h0, 64'h1234, 0, 0, 64'h1234, 1, 0, 3'b100, 6, 0);
        vecs[6]  = mk(4'h4, 4'h0, 0, 64'h100, 64'h18, 64'h118, 0, 0, 3'b100, 7, 0);
        vecs[7]  = mk(4'hA, 4'h0, 0, 64'h200, 0, 64'h1F8, 0, 0, 3'b100, 8, 0);
        vecs[8]  = mk(4'hB, 4'h0, 0, 64'h200, 0, 64'h208, 0, 0, 3'b100, 9, 0);
        vecs[9]  = mk(4'h3, 4'h0, 0, 0, 64'hDEAD, 64'hDEAD, 0, 0, 3'b100, 10, 0);
        vecs[10] = mk(4'h5, 4'h0, 0, 64'h10, 64'hFFFF_FFFF_FFFF_FFF8, 64'h8, 0, 0,
                      3'b100, 11, 0);
        vecs[11] = mk(4'h8, 4'h0, 0, 64'h8, 0, 0, 0, 0, 3'b100, 12, 0);
        vecs[12] = mk(4'h9, 4'h0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, 0, 3'b100, 13, 0);
        vecs[13] = mk(4'h6, 4'h2, 64'hF0F0, 64'hFF00, 0, 64'hF000, 0, 0, 3'b000, 14, 0);
        vecs[14] = mk(4'h7, 4'h5, 0, 0, 0, 0, 1, 0, 3'b000, 15, 0);
        vecs[15] = mk(4'h7, 4'h6, 0, 0, 0, 0, 1, 0, 3'b000, 16, 0);
        vecs[16] = mk(4'h6, 4'h1, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 3'b010, 17, 0);
        vecs[17] = mk(4'h7, 4'h1, 0, 0, 0, 0, 1, 0, 3'b010, 18, 0);
        vecs[18] = mk(4'h7, 4'h7, 0, 0, 0, 0, 0, 1, 3'b010, 18, 0);
        vecs[19] = mk(4'h6, 4'h7, 1, 2, 0, 0, 0, 1, 3'b010, 18, 0);
        vecs[20] = mk(4'hC, 4'h0, 0, 64'd10, 64'hFFFF_FFFF_FFFF_FFFD,
                      IaddEn ? 64'd7 : 64'd0, 0, !IaddEn, cc21, r21, 0);
        vecs[21] = mk(4'hD, 4'h0, 0, 1, 1, 0, 0, 1, cc21, r21, 0);
        vecs[22] = mk(4'h7, 4'h4, 0, 0, 0, 0, 1, 0, cc21, r21 + 1, 0);
        vecs[23] = mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 0, cc21, r21 + 2, 0);
        vecs[24] = mk(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, cc21, r21 + 3, 1);
        vecs[25] = mk(4'h6, 4'h3, 3, 3, 0, 0, 0, 0, cc21, r21 + 3, 1);
        vecs[26] = mk(4'h2, 4'h4, 64'h77, 0, 0, 64'h77, 1, 0, cc21, r21 + 3, 1);

        // Reset and check the initial state
        drive(1'b1, 4'h1, 4'h0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cc", 64'(cc), 64'(3'b100));
        chk("reset_halted", 64'(halted), 64'(0));
        chk("reset_retired", 64'(retired), 64'(0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(1'b0, vecs[i].icode, vecs[i].ifun, vecs[i].a, vecs[i].b, vecs[i].c);
            sb.push_back(vecs[i]);
            #2;
            cur = sb.pop_front();
            chk($sformatf("v%0d_valE", i), valE, cur.e);
            chk($sformatf("v%0d_Cnd", i), 64'(Cnd), 64'(cur.cnd));
            chk($sformatf("v%0d_ins_err", i), 64'(insErr), 64'(cur.err));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_cc", i), 64'(cc), 64'(cur.ccAfter));
            chk($sformatf("v%0d_retired", i), 64'(retired), 64'(cur.retAfter));
            chk($sformatf("v%0d_halted", i), 64'(halted), 64'(cur.haltAfter));
            chk($sformatf("v%0d_retired_narrow", i), 64'(retired2),
                64'(cur.retAfter % 8));
        end
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));

        // Reset releases the halt and clears the state
        @(negedge clk);
        drive(1'b1, 4'h1, 4'h0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("rst_halted", 64'(halted), 64'(0));
        chk("rst_retired", 64'(retired), 64'(0));
        chk("rst_cc", 64'(cc), 64'(3'b100));

        // Halt in the same cycle as reset: reset wins
        @(negedge clk);
        drive(1'b1, 4'h0, 4'h0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("rst_vs_halt", 64'(halted), 64'(0));
        chk("rst_vs_halt_retired", 64'(retired), 64'(0));

        // Nine nops: the 3-bit counter wraps to 1
        @(negedge clk);
        drive(1'b0, 4'h1, 4'h0, 0, 0, 0);
        repeat (9) @(posedge clk);
        #1;
        chk("nop_retired", 64'(retired), 64'(9));
        chk("wrap_retired_narrow", 64'(retired2), 64'(1));
        chk("nop_halted", 64'(halted), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
